// File: rtl/alu_pkg.sv
// Shared types, opcodes, directed-vector ROM and MISR helpers for the ALU BIST controller.
// ALU_BIST_GOLDEN_SIG is the ALU_BIST_MISR_EN signature expected from a correct ALU.
package alu_pkg;

   localparam int unsigned XLEN    = 64;
   localparam int unsigned NUM_VEC = 20;
   localparam int unsigned IDX_W   = 5;
   localparam int unsigned CTRL_W  = 4;

   localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
   localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
   localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
   localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
   localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0101;
   localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0110;
   localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0111;
   localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1000;
   localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1001;
   localparam logic [CTRL_W-1:0] ALU_NOP  = 4'b1111;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [XLEN-1:0]   rs1;
      logic [XLEN-1:0]   rs2;
      logic [XLEN-1:0]   exp;
   } alu_vec_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
      ST_DONE
   } bist_state_e;

   // x^64 + x^4 + x^3 + x + 1, Galois form shifting toward the MSB
   localparam logic [XLEN-1:0] MISR_POLY = 64'h0000_0000_0000_001B;
   localparam logic [XLEN-1:0] MISR_SEED = '1;

   function automatic logic [XLEN-1:0] misr_step(input logic [XLEN-1:0] sig,
                                                 input logic [XLEN-1:0] data);
      return {sig[XLEN-2:0], 1'b0} ^ (sig[XLEN-1] ? MISR_POLY : '0) ^ data;
   endfunction

   function automatic alu_vec_t rom_vec(input logic [IDX_W-1:0] idx);
      alu_vec_t v;
      v = '{ctrl: ALU_NOP, rs1: '0, rs2: '0, exp: '0};
      case (idx)
         5'd0:  v = '{ALU_ADD,  64'h0,                   64'h0,                   64'h0};
         5'd1:  v = '{ALU_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h0};
         5'd2:  v = '{ALU_ADD,  64'h5,                   64'hA,                   64'hF};
         5'd3:  v = '{ALU_SUB,  64'hA,                   64'hA,                   64'h0};
         5'd4:  v = '{ALU_SUB,  64'h0,                   64'h1,                   64'hFFFF_FFFF_FFFF_FFFF};
         5'd5:  v = '{ALU_SUB,  64'h14,                  64'h5,                   64'hF};
         5'd6:  v = '{ALU_AND,  64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0000_0F0F_0000};
         5'd7:  v = '{ALU_OR,   64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_0F0F_FFFF_0F0F};
         5'd8:  v = '{ALU_XOR,  64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_0F0F_F0F0_0F0F};
         5'd9:  v = '{ALU_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h1};
         5'd10: v = '{ALU_SLT,  64'h5,                   64'h5,                   64'h0};
         5'd11: v = '{ALU_SLT,  64'hA,                   64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
         5'd12: v = '{ALU_SLL,  64'h1,                   64'h0,                   64'h1};
         5'd13: v = '{ALU_SLL,  64'h1,                   64'h3F,                  64'h8000_0000_0000_0000};
         5'd14: v = '{ALU_SRL,  64'h8000_0000_0000_0000, 64'h3F,                  64'h1};
         5'd15: v = '{ALU_SRA,  64'hFFFF_FFFF_FFFF_FFFF, 64'h4,                   64'hFFFF_FFFF_FFFF_FFFF};
         5'd16: v = '{ALU_SRA,  64'hFFFF_FFFF_FFFF_FFF8, 64'h2,                   64'hFFFF_FFFF_FFFF_FFFE};
         5'd17: v = '{ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   64'h0};
         5'd18: v = '{ALU_SLTU, 64'h1,                   64'h2,                   64'h1};
         5'd19: v = '{ALU_NOP,  64'h1234,                64'h5678,                64'h0};
         default: v = '{ctrl: ALU_NOP, rs1: '0, rs2: '0, exp: '0};
      endcase
      return v;
   endfunction

   // Signature a correct ALU produces: every sampled result equals its golden value
   function automatic logic [XLEN-1:0] calc_golden_sig();
      logic [XLEN-1:0] sig;
      alu_vec_t        v;
      sig = MISR_SEED;
      for (int i = 0; i < int'(NUM_VEC); i++) begin
         v   = rom_vec(IDX_W'(i));
         sig = misr_step(sig, v.exp);
      end
      return sig;
   endfunction

   localparam logic [XLEN-1:0] ALU_BIST_GOLDEN_SIG = calc_golden_sig();

endpackage

// File: rtl/alu_bist_rom.sv
// Directed-vector ROM: combinational index to {ctrl, rs1, rs2, exp} lookup.
module alu_bist_rom
   import alu_pkg::*;
(
   input  logic [IDX_W-1:0] idx_i,
   output alu_vec_t         vec_c
);

   assign vec_c = rom_vec(idx_i);

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test controller: drives ROM vectors onto the ALU inputs and checks results.
// Defining ALU_BIST_MISR_EN adds a result-compacting MISR output, misr_sig.
module alu_bist
   import alu_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [XLEN-1:0]   alu_rs1_data,
   output logic [XLEN-1:0]   alu_rs2_data,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [XLEN-1:0]   alu_result,
   input  logic              alu_zero,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_count,
   output logic [IDX_W-1:0]  first_fail_idx,
   output logic [XLEN-1:0]   first_fail_got
`ifdef ALU_BIST_MISR_EN
   ,
   output logic [XLEN-1:0]   misr_sig
`endif
);

   localparam int unsigned CNT_W = 4;

   bist_state_e       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, exp_q, exp_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [7:0]        err_q, err_d;
   logic [IDX_W-1:0]  ff_idx_q, ff_idx_d;
   logic [XLEN-1:0]   ff_got_q, ff_got_d;
   logic              run_start_c, sample_c, mismatch_c;
   alu_vec_t          rom_vec_c;

   // Looked up at the next index so operands land in flops as DRIVE is entered
   alu_bist_rom u_rom (
      .idx_i (idx_d),
      .vec_c (rom_vec_c)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      run_start_c = 1'b0;
      sample_c    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_DRIVE;
               idx_d       = '0;
               cnt_d       = '0;
               run_start_c = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_SAMPLE;
            else                                   cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_SAMPLE: begin
            sample_c = 1'b1;
            if (idx_q == IDX_W'(NUM_VEC - 1)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRIVE;
               idx_d   = idx_q + IDX_W'(1);
               cnt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mismatch_c = (alu_result != exp_q) || (alu_zero != (exp_q == '0));

   always_comb begin
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      ctrl_d   = ctrl_q;
      exp_d    = exp_q;
      err_d    = err_q;
      ff_idx_d = ff_idx_q;
      ff_got_d = ff_got_q;
      if (run_start_c) begin
         err_d    = '0;
         ff_idx_d = '0;
         ff_got_d = '0;
      end
      if (sample_c && mismatch_c) begin
         err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
         if (err_q == 8'd0) begin
            ff_idx_d = idx_q;
            ff_got_d = alu_result;
         end
      end
      if (state_d == ST_DRIVE && state_q != ST_DRIVE) begin
         rs1_d  = rom_vec_c.rs1;
         rs2_d  = rom_vec_c.rs2;
         ctrl_d = rom_vec_c.ctrl;
         exp_d  = rom_vec_c.exp;
      end else if (state_d == ST_IDLE || state_d == ST_DONE) begin
         rs1_d  = '0;
         rs2_d  = '0;
         ctrl_d = ALU_NOP;
         exp_d  = '0;
      end
      busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
      done_d = (state_d == ST_DONE);
      pass_d = done_d && (err_d == 8'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         ctrl_q   <= ALU_NOP;
         exp_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         ff_idx_q <= '0;
         ff_got_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         ctrl_q   <= ctrl_d;
         exp_q    <= exp_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         ff_idx_q <= ff_idx_d;
         ff_got_q <= ff_got_d;
      end
   end

`ifdef ALU_BIST_MISR_EN
   logic [XLEN-1:0] misr_q, misr_d;

   always_comb begin
      misr_d = misr_q;
      if (run_start_c)   misr_d = MISR_SEED;
      else if (sample_c) misr_d = misr_step(misr_q, alu_result);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misr_q <= MISR_SEED;
      else        misr_q <= misr_d;
   end

   assign misr_sig = misr_q;
`endif

   assign alu_rs1_data   = rs1_q;
   assign alu_rs2_data   = rs2_q;
   assign alu_ctrl       = ctrl_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_fail_idx = ff_idx_q;
   assign first_fail_got = ff_got_q;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: behavioural ALU with fault injection and a run-level reference model.
module tb_alu_bist;
   import alu_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [XLEN-1:0]   alu_rs1_data, alu_rs2_data, alu_result;
   logic [CTRL_W-1:0] alu_ctrl;
   logic              alu_zero;
   logic              busy, done, pass;
   logic [7:0]        err_count;
   logic [IDX_W-1:0]  first_fail_idx;
   logic [XLEN-1:0]   first_fail_got;
`ifdef ALU_BIST_MISR_EN
   logic [XLEN-1:0]   misr_sig;
`endif

   // Fault injection knobs for the bench ALU
   logic [3:0]        flt_op;
   logic [XLEN-1:0]   flt_mask;
   logic              zero_force0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_bist dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .alu_rs1_data   (alu_rs1_data),
      .alu_rs2_data   (alu_rs2_data),
      .alu_ctrl       (alu_ctrl),
      .alu_result     (alu_result),
      .alu_zero       (alu_zero),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_fail_idx (first_fail_idx),
      .first_fail_got (first_fail_got)
`ifdef ALU_BIST_MISR_EN
      ,
      .misr_sig       (misr_sig)
`endif
   );

   // Directed vectors as listed for the ROM
   logic [3:0]  tv_op  [20] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8, 4'd8, 4'd9, 4'd9, 4'd15};
   logic [63:0] tv_a   [20] = '{64'h0, '1, 64'h5, 64'd10, 64'h0, 64'd20,
                                64'hFFFF0000FFFF0000, 64'hFFFF0000FFFF0000, 64'hFFFF0000FFFF0000,
                                '1, 64'd5, 64'd10, 64'h1, 64'h1, 64'h8000000000000000,
                                '1, -64'sd8, '1, 64'h1, 64'h1234};
   logic [63:0] tv_b   [20] = '{64'h0, 64'h1, 64'd10, 64'd10, 64'h1, 64'd5,
                                64'h0F0F0F0F0F0F0F0F, 64'h0F0F0F0F0F0F0F0F, 64'h0F0F0F0F0F0F0F0F,
                                64'h1, 64'd5, '1, 64'h0, 64'd63, 64'd63,
                                64'd4, 64'd2, 64'h0, 64'h2, 64'h5678};
   logic [63:0] tv_exp [20] = '{64'h0, 64'h0, 64'd15, 64'h0, '1, 64'd15,
                                64'h0F0F00000F0F0000, 64'hFFFF0F0FFFFF0F0F, 64'hF0F00F0FF0F00F0F,
                                64'h1, 64'h0, 64'h0, 64'h1, 64'h8000000000000000, 64'h1,
                                '1, -64'sd2, 64'h0, 64'h1, 64'h0};

   function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         4'd6: return a << b[5:0];
         4'd7: return a >> b[5:0];
         4'd8: return 64'($signed(a) >>> b[5:0]);
         4'd9: return (a < b) ? 64'd1 : 64'd0;
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] faulty_alu(input logic [3:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
      logic [63:0] r;
      r = ref_alu(op, a, b);
      if (op == flt_op) r = r ^ flt_mask;
      return r;
   endfunction

   always_comb begin
      alu_result = faulty_alu(alu_ctrl, alu_rs1_data, alu_rs2_data);
      alu_zero   = zero_force0 ? 1'b0 : (alu_result == 64'd0);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Predicts the outcome of one full run under the current fault settings
   task automatic model_run(output int e_err, output int e_idx, output logic [63:0] e_got,
                            output logic [63:0] e_sig);
      logic [63:0] r, sig;
      logic        z;
      e_err = 0; e_idx = 0; e_got = 0; sig = '1;
      for (int i = 0; i < 20; i++) begin
         r = faulty_alu(tv_op[i], tv_a[i], tv_b[i]);
         z = zero_force0 ? 1'b0 : (r == 0);
         if (r != tv_exp[i] || z != (tv_exp[i] == 0)) begin
            if (e_err == 0) begin e_idx = i; e_got = r; end
            if (e_err < 255) e_err++;
         end
         sig = {sig[62:0], 1'b0} ^ (sig[63] ? 64'h1B : 64'h0) ^ r;
      end
      e_sig = sig;
   endtask

   // Pulses start, follows the run checking operands, and returns the cycles until done
   task automatic run_bist(input string tag, input int repulse_at, output int lat);
      int cyc;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      cyc = 0;
      lat = -1;
      while (cyc <= 100) begin
         @(negedge clk);
         if (done) begin lat = cyc; break; end
         if (cyc < 40) begin
            check({tag, "_ctrl"}, 64'(alu_ctrl), 64'(tv_op[cyc/2]));
            check({tag, "_rs1"}, alu_rs1_data, tv_a[cyc/2]);
            check({tag, "_rs2"}, alu_rs2_data, tv_b[cyc/2]);
         end
         start = (cyc == repulse_at) ? 1'b1 : 1'b0;
         @(posedge clk);
         cyc++;
      end
      start = 1'b0;
      check({tag, "_latency"}, 64'(lat), 64'd40);
   endtask

   task automatic check_results(input string tag, input logic expect_golden);
      int          e_err, e_idx;
      logic [63:0] e_got, e_sig;
      model_run(e_err, e_idx, e_got, e_sig);
      check({tag, "_err_count"}, 64'(err_count), 64'(e_err));
      check({tag, "_ff_idx"}, 64'(first_fail_idx), 64'(e_idx));
      check({tag, "_ff_got"}, first_fail_got, e_got);
      check({tag, "_pass"}, 64'(pass), 64'(e_err == 0));
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_idle_ctrl"}, 64'(alu_ctrl), 64'hF);
      check({tag, "_idle_rs1"}, alu_rs1_data, 64'd0);
`ifdef ALU_BIST_MISR_EN
      check({tag, "_misr"}, misr_sig, e_sig);
      if (expect_golden) check({tag, "_misr_golden"}, misr_sig, ALU_BIST_GOLDEN_SIG);
`else
      if (expect_golden) check({tag, "_model_sig_nonzero"}, 64'(e_sig != 0), 64'd1);
`endif
   endtask

   task automatic set_fault(input logic [3:0] op, input logic [63:0] mask, input logic z0);
      flt_op = op; flt_mask = mask; zero_force0 = z0;
   endtask

   initial begin
      int lat;
      start = 1'b0;
      rst_n = 1'b0;
      set_fault(4'hE, 64'd0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_pass", 64'(pass), 64'd0);
      check("rst_err", 64'(err_count), 64'd0);
      check("rst_ctrl", 64'(alu_ctrl), 64'hF);
      check("rst_rs1", alu_rs1_data, 64'd0);
      check("rst_rs2", alu_rs2_data, 64'd0);
      check("rst_ff_got", first_fail_got, 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Correct ALU
      run_bist("good", -1, lat);
      check_results("good", 1'b1);
      check("good_done_level", 64'(done), 64'd1);

      // SUB results off by one in bit 0
      set_fault(ALU_SUB, 64'd1, 1'b0);
      run_bist("sub", -1, lat);
      check_results("sub", 1'b0);
      check("sub_err_const", 64'(err_count), 64'd3);

      // Zero flag stuck low
      set_fault(4'hE, 64'd0, 1'b1);
      run_bist("zero", -1, lat);
      check_results("zero", 1'b0);
      check("zero_err_const", 64'(err_count), 64'd7);

      // Restart from DONE with a correct ALU; done must drop the following cycle
      set_fault(4'hE, 64'd0, 1'b0);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("restart_done_drop", 64'(done), 64'd0);
      check("restart_busy", 64'(busy), 64'd1);
      repeat (45) @(negedge clk);
      check("restart_done", 64'(done), 64'd1);
      check_results("restart", 1'b1);

      // start re-pulsed mid-run is ignored
      run_bist("repulse", 5, lat);
      check_results("repulse", 1'b1);

      // Asynchronous reset mid-run
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_ctrl", 64'(alu_ctrl), 64'hF);
      check("arst_done", 64'(done), 64'd0);
      check("arst_rs1", alu_rs1_data, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      run_bist("post_rst", -1, lat);
      check_results("post_rst", 1'b1);

      // Randomized single-opcode corruption with random idle gaps
      for (int k = 0; k < 4; k++) begin
         set_fault(4'($urandom_range(0, 9)), {$urandom, $urandom} | 64'h1, 1'($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 4)) @(negedge clk);
         run_bist($sformatf("rnd%0d", k), -1, lat);
         check_results($sformatf("rnd%0d", k), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
